// File: rtl/stopwatch_sequencer.sv
// Stopwatch run controller: command FSM, increment prescaler and
// lap-display hold control for the counter/display datapath.
module stopwatch_sequencer #(
  parameter int DIV        = 100,
  parameter int HOLD_TICKS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic       cnt_inc,
  output logic       cnt_clr,
  output logic       lap_latch,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam int PW = $clog2(DIV);
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [HW-1:0] HMAX =
    HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t          st;
  state_t          nxt;
  logic [PW-1:0]   ps;
  logic [HW-1:0]   hc;
  logic            active;
  logic            auto_rel;

  assign active   = (st == RUN) || (st == LAP);
  assign cnt_inc  = active && (ps == PMAX);
  assign auto_rel = (HOLD_TICKS > 0) && (st == LAP)
                    && cnt_inc && (hc == HMAX);
  assign state    = st;

  // clear > stop > start > lap; auto-release folds into the lap path
  always_comb begin
    nxt = st;
    if (clear) begin
      nxt = IDLE;
    end else begin
      case (st)
        IDLE:  if (start) nxt = RUN;
        RUN:   if (stop) nxt = PAUSE;
               else if (lap) nxt = LAP;
        PAUSE: if (start) nxt = RUN;
        LAP:   if (stop) nxt = PAUSE;
               else if (lap || auto_rel) nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      ps        <= '0;
      hc        <= '0;
      cnt_clr   <= 1'b0;
      lap_latch <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      st        <= nxt;
      cnt_clr   <= clear;
      lap_latch <= (st == RUN) && (nxt == LAP);
      disp_hold <= (nxt == LAP);
      // PAUSE keeps the partial period so resume continues it
      if (clear || (st == IDLE)) begin
        ps <= '0;
      end else if (active) begin
        ps <= (ps == PMAX) ? '0 : ps + 1'b1;
      end
      if ((nxt == LAP) && (st != LAP)) begin
        hc <= '0;
      end else if ((st == LAP) && cnt_inc) begin
        hc <= hc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Bench for stopwatch_sequencer: two builds (auto-release and manual)
// checked every cycle against a behavioural model, plus directed cases.
module tb_stopwatch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic a_inc, a_clr, a_latch, a_hold;
  logic b_inc, b_clr, b_latch, b_hold;
  logic [1:0] a_state, b_state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_sequencer #(.DIV(4), .HOLD_TICKS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .cnt_inc(a_inc), .cnt_clr(a_clr),
    .lap_latch(a_latch), .disp_hold(a_hold), .state(a_state)
  );

  stopwatch_sequencer #(.DIV(4), .HOLD_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clear(clear), .lap(lap), .cnt_inc(b_inc), .cnt_clr(b_clr),
    .lap_latch(b_latch), .disp_hold(b_hold), .state(b_state)
  );

  // mode: 0 idle, 1 run, 2 pause, 3 lap; phase = cycles into period
  typedef struct {
    int mode;
    int phase;
    int laps;
    bit clr;
    bit latch;
    bit hold;
  } model_t;

  model_t ma, mb;

  function automatic bit m_inc(model_t m, int div);
    return (m.mode == 1 || m.mode == 3) && m.phase == div - 1;
  endfunction

  function automatic model_t step(model_t m, int div, int ht,
                                  bit s, bit p, bit c, bit l);
    model_t r;
    bit timing = (m.mode == 1 || m.mode == 3);
    bit inc = m_inc(m, div);
    bit rel = ht > 0 && m.mode == 3 && inc && m.laps + 1 == ht;
    int n = m.mode;
    if (c) n = 0;
    else if (m.mode == 0 && s) n = 1;
    else if (m.mode == 1 && p) n = 2;
    else if (m.mode == 1 && l) n = 3;
    else if (m.mode == 2 && s) n = 1;
    else if (m.mode == 3 && p) n = 2;
    else if (m.mode == 3 && (l || rel)) n = 1;
    if (c || m.mode == 0) r.phase = 0;
    else if (timing) r.phase = (m.phase + 1) % div;
    else r.phase = m.phase;
    if (n == 3 && m.mode != 3) r.laps = 0;
    else r.laps = m.laps + ((m.mode == 3 && inc) ? 1 : 0);
    r.mode = n;
    r.clr = c;
    r.latch = (m.mode == 1 && n == 3);
    r.hold = (n == 3);
    return r;
  endfunction

  function automatic logic [5:0] m_out(model_t m, int div);
    return {2'(m.mode), m_inc(m, div), m.clr, m.latch, m.hold};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = step(ma, 4, 2, start, stop, clear, lap);
      mb = step(mb, 4, 0, start, stop, clear, lap);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_a", 32'({a_state, a_inc, a_clr, a_latch, a_hold}),
          32'(m_out(ma, 4)));
      chk("model_b", 32'({b_state, b_inc, b_clr, b_latch, b_hold}),
          32'(m_out(mb, 4)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(bit s, bit p, bit c, bit l);
    start = s; stop = p; clear = c; lap = l;
    tick();
    start = 0; stop = 0; clear = 0; lap = 0;
  endtask

  int n;
  int k;

  initial begin
    repeat (2) tick();
    chk("reset_outs", 32'({a_state, a_inc, a_clr, a_latch, a_hold}), 0);
    @(negedge clk);
    rst = 1'b0;

    // start at edge 0; increments in cycles 3, 7, 11
    pulse(1, 0, 0, 0);
    chk("run_state", 32'(a_state), 1);
    for (int c = 0; c < 12; c++) begin
      chk("inc_cycle", 32'(a_inc), 32'(c == 3 || c == 7 || c == 11));
      chk("no_clr", 32'(a_clr), 0);
      tick();
    end

    // pause with prescaler at 2, resume continues the period
    repeat (2) tick();
    pulse(0, 1, 0, 0);
    chk("pause_state", 32'(a_state), 2);
    n = 0;
    repeat (10) begin
      n += int'(a_inc);
      tick();
    end
    chk("pause_no_inc", 32'(n), 0);
    pulse(1, 0, 0, 0);
    chk("resume_state", 32'(a_state), 1);
    chk("resume_inc", 32'(a_inc), 1);

    // lap with auto-release after two increments
    pulse(0, 0, 0, 1);
    chk("lap_state", 32'(a_state), 3);
    chk("lap_latch", 32'(a_latch), 1);
    chk("lap_hold", 32'(a_hold), 1);
    n = 0;
    k = 0;
    while (a_state == 2'b11 && k < 20) begin
      n += int'(a_inc);
      tick();
      k++;
    end
    chk("auto_cycles", 32'(k), 8);
    chk("auto_incs", 32'(n), 2);
    chk("auto_state", 32'(a_state), 1);
    chk("auto_hold", 32'(a_hold), 0);
    chk("manual_stays", 32'(b_state), 3);

    // manual-only build: hold for exactly 20 cycles
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    tick();
    pulse(0, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n += int'(b_hold);
      if (i == 19) lap = 1;
      tick();
    end
    lap = 0;
    chk("manual_hold_n", 32'(n), 20);
    chk("manual_release", 32'(b_hold), 0);
    chk("manual_state", 32'(b_state), 1);

    // coincident stop/start/clear from RUN
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    repeat (2) tick();
    pulse(1, 1, 1, 0);
    chk("clr_state", 32'(a_state), 0);
    chk("clr_pulse", 32'(a_clr), 1);
    tick();
    chk("clr_one", 32'(a_clr), 0);
    repeat (5) tick();
    pulse(1, 0, 0, 0);
    k = 0;
    while (!a_inc && k < 10) begin
      tick();
      k++;
    end
    chk("first_inc_lat", 32'(k), 3);

    // async reset while in LAP with prescaler 3
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    repeat (2) tick();
    chk("pre_rst_lap", 32'({a_state, a_inc}), 32'b111);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({a_state, a_inc, a_clr, a_latch, a_hold}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst", 32'({a_state, a_inc, a_clr, a_latch, a_hold}), 0);

    // randomized command traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      lap   = ($urandom_range(0, 11) == 0);
      clear = ($urandom_range(0, 79) == 0);
      tick();
    end
    start = 0; stop = 0; lap = 0; clear = 0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
